// File: rtl/seg7_scan_to_bcd.sv
// seg7_scan_to_bcd: snoops a scanned 7-segment bus, qualifies each digit for stability, decodes it to BCD
// and assembles NUM_DIGITS digits into a frame. Optional macro SEG7_ACTIVE_LOW_EN selects active-low pins.
`default_nettype none

module seg7_scan_to_bcd #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    seg_a,
   input  logic                    seg_b,
   input  logic                    seg_c,
   input  logic                    seg_d,
   input  logic                    seg_e,
   input  logic                    seg_f,
   input  logic                    seg_g,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    digit_valid,
   output logic [IDX_W-1:0]        digit_idx,
   output logic [3:0]              digit_bcd,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic                    frame_valid
);

   localparam int SW = NUM_DIGITS + 7;

   logic [SW-1:0]           pins;
   logic [SW-1:0]           sample;
   logic [SW-1:0]           cur;
   logic [CNT_W-1:0]        cnt;
   logic                    done;
   logic [NUM_DIGITS-1:0]   seen;
   logic [4*NUM_DIGITS-1:0] shadow_bcd;
   logic [NUM_DIGITS-1:0]   shadow_err;

   logic [NUM_DIGITS-1:0]   sel;
   logic [6:0]              seg;
   logic                    one_hot;
   logic [IDX_W-1:0]        sel_idx;
   logic [3:0]              dec_val;
   logic                    dec_err;
   logic                    capture;
   logic [NUM_DIGITS-1:0]   merged_seen;
   logic [4*NUM_DIGITS-1:0] next_bcd;
   logic [NUM_DIGITS-1:0]   next_err;

   assign pins = {dig_sel, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

   // The sample register holds pin-level data so its reset value equals an idle bus.
`ifdef SEG7_ACTIVE_LOW_EN
   localparam logic [SW-1:0] IDLE = '1;
   assign cur = ~sample;
`else
   localparam logic [SW-1:0] IDLE = '0;
   assign cur = sample;
`endif

   assign sel = cur[SW-1:7];
   assign seg = cur[6:0];

   always_comb begin
      one_hot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel[i]) sel_idx = IDX_W'(i);
      end
   end

   always_comb begin
      dec_err = 1'b0;
      case (seg)
         7'b1111110: dec_val = 4'd0;
         7'b0110000: dec_val = 4'd1;
         7'b1101101: dec_val = 4'd2;
         7'b1111001: dec_val = 4'd3;
         7'b0110011: dec_val = 4'd4;
         7'b1011011: dec_val = 4'd5;
         7'b1011111: dec_val = 4'd6;
         7'b1110000: dec_val = 4'd7;
         7'b1111111: dec_val = 4'd8;
         7'b1111011: dec_val = 4'd9;
         default: begin
            dec_val = 4'hF;
            dec_err = 1'b1;
         end
      endcase
   end

   // done marks that the current stable pattern was already offered for capture.
   assign capture     = (cnt == CNT_W'(STABLE_CYCLES)) && !done && one_hot;
   assign merged_seen = seen | sel;

   always_comb begin
      next_bcd = shadow_bcd;
      next_err = shadow_err;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel[i]) begin
            next_bcd[4*i +: 4] = dec_val;
            next_err[i]        = dec_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample      <= IDLE;
         cnt         <= '0;
         done        <= 1'b0;
         seen        <= '0;
         shadow_bcd  <= '0;
         shadow_err  <= '0;
         digit_valid <= 1'b0;
         digit_idx   <= '0;
         digit_bcd   <= '0;
         bcd_out     <= '0;
         err_mask    <= '0;
         frame_valid <= 1'b0;
      end else begin
         sample      <= pins;
         digit_valid <= capture;
         frame_valid <= 1'b0;
         if (pins != sample) begin
            cnt  <= CNT_W'(1);
            done <= 1'b0;
         end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            done <= 1'b1;
         end
         if (capture) begin
            digit_idx  <= sel_idx;
            digit_bcd  <= dec_val;
            shadow_bcd <= next_bcd;
            shadow_err <= next_err;
            if (&merged_seen) begin
               bcd_out     <= next_bcd;
               err_mask    <= next_err;
               frame_valid <= 1'b1;
               seen        <= '0;
            end else begin
               seen <= merged_seen;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_to_bcd.sv
// Bench for seg7_scan_to_bcd: directed vector table, reset-mid-frame sequence and randomized scan
// traffic compared every cycle against a run-length based reference model.
`default_nettype none

module tb_seg7_scan_to_bcd;
   localparam int N = 4;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   l_dig;
   logic [6:0]   l_seg;
   logic [3:0]   p_dig;
   logic [6:0]   p_seg;
   logic         digit_valid, frame_valid;
   logic [1:0]   digit_idx;
   logic [3:0]   digit_bcd;
   logic [15:0]  bcd_out;
   logic [3:0]   err_mask;

`ifdef SEG7_ACTIVE_LOW_EN
   assign {p_dig, p_seg} = ~{l_dig, l_seg};
`else
   assign {p_dig, p_seg} = {l_dig, l_seg};
`endif

   seg7_scan_to_bcd #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .seg_a(p_seg[6]), .seg_b(p_seg[5]), .seg_c(p_seg[4]), .seg_d(p_seg[3]),
      .seg_e(p_seg[2]), .seg_f(p_seg[1]), .seg_g(p_seg[0]),
      .dig_sel(p_dig),
      .digit_valid(digit_valid), .digit_idx(digit_idx), .digit_bcd(digit_bcd),
      .bcd_out(bcd_out), .err_mask(err_mask), .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   logic [3:0]  prev_dig = '0;
   logic [6:0]  prev_seg = '0;
   int          run = 0;
   logic        m_dv = 0, m_fv = 0;
   int          m_idx = 0, m_bcd = 0;
   logic [15:0] m_bout = '0;
   logic [3:0]  m_err = '0;
   int          sh_val [N];
   bit          sh_err [N];
   bit          seen [N];
   int          d, v;
   bit          all_seen;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_dig = '0; prev_seg = '0; run = 0;
         m_dv = 0; m_fv = 0; m_idx = 0; m_bcd = 0; m_bout = '0; m_err = '0;
         for (int j = 0; j < N; j++) begin sh_val[j] = 0; sh_err[j] = 0; seen[j] = 0; end
      end else begin
         m_dv = 0;
         m_fv = 0;
         // A pattern is accepted once, exactly when its run of identical samples reaches S.
         if (run == S && $countones(prev_dig) == 1) begin
            d = 0;
            for (int j = 0; j < N; j++) if (prev_dig[j]) d = j;
            v = 15;
            for (int j = 0; j < 10; j++) if (pat[j] == prev_seg) v = j;
            m_dv = 1; m_idx = d; m_bcd = v;
            sh_val[d] = v; sh_err[d] = (v == 15); seen[d] = 1;
            all_seen = 1;
            for (int j = 0; j < N; j++) if (!seen[j]) all_seen = 0;
            if (all_seen) begin
               m_fv = 1;
               for (int j = 0; j < N; j++) begin
                  m_bout[4*j +: 4] = sh_val[j][3:0];
                  m_err[j] = sh_err[j];
                  seen[j] = 0;
               end
            end
         end
         if ({l_dig, l_seg} != {prev_dig, prev_seg}) run = 1;
         else run++;
         prev_dig = l_dig;
         prev_seg = l_seg;
      end
   end

   // ---------------- monitor ----------------
   bit         mon_en = 0;
   int         dv_total = 0, fv_total = 0;
   logic [1:0] last_idx = '0;
   logic [3:0] last_bcd = '0;

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         chk("cyc_digit_valid", digit_valid, m_dv);
         chk("cyc_frame_valid", frame_valid, m_fv);
         chk("cyc_bcd_out", bcd_out, m_bout);
         chk("cyc_err_mask", err_mask, m_err);
         if (m_dv) begin
            chk("cyc_digit_idx", digit_idx, m_idx);
            chk("cyc_digit_bcd", digit_bcd, m_bcd);
         end
         if (digit_valid === 1'b1) begin
            dv_total++;
            last_idx = digit_idx;
            last_bcd = digit_bcd;
         end
         if (frame_valid === 1'b1) fv_total++;
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  dig;
      logic [6:0]  seg;
      int          hold;
      int          n_dv;
      logic [1:0]  idx;
      logic [3:0]  bcd;
      int          n_fv;
      logic [15:0] bout;
      logic [3:0]  err;
   } row_t;

   row_t rows [12];

   task automatic run_row(input row_t r, input string nm);
      int dv0 = dv_total;
      int fv0 = fv_total;
      l_dig = r.dig;
      l_seg = r.seg;
      repeat (r.hold) @(negedge clk);
      l_dig = '0;
      l_seg = '0;
      @(negedge clk);
      chk({nm, "_dv_count"}, dv_total - dv0, r.n_dv);
      if (r.n_dv > 0) begin
         chk({nm, "_idx"}, last_idx, r.idx);
         chk({nm, "_bcd"}, last_bcd, r.bcd);
      end
      chk({nm, "_fv_count"}, fv_total - fv0, r.n_fv);
      chk({nm, "_bcd_out"}, bcd_out, r.bout);
      chk({nm, "_err_mask"}, err_mask, r.err);
   endtask

   initial begin
      rows[0]  = '{4'b0001, 7'b1111001, 4,  1, 2'd0, 4'd3, 0, 16'h0000, 4'b0000};
      rows[1]  = '{4'b0001, 7'b0110000, 6,  1, 2'd0, 4'd1, 0, 16'h0000, 4'b0000};
      rows[2]  = '{4'b0010, 7'b1101101, 6,  1, 2'd1, 4'd2, 0, 16'h0000, 4'b0000};
      rows[3]  = '{4'b0100, 7'b1111001, 6,  1, 2'd2, 4'd3, 0, 16'h0000, 4'b0000};
      rows[4]  = '{4'b1000, 7'b0110011, 6,  1, 2'd3, 4'd4, 1, 16'h4321, 4'b0000};
      rows[5]  = '{4'b0001, 7'b1111001, 3,  0, 2'd0, 4'd0, 0, 16'h4321, 4'b0000};
      rows[6]  = '{4'b0011, 7'b1111111, 10, 0, 2'd0, 4'd0, 0, 16'h4321, 4'b0000};
      rows[7]  = '{4'b0000, 7'b1111111, 10, 0, 2'd0, 4'd0, 0, 16'h4321, 4'b0000};
      rows[8]  = '{4'b0001, 7'b1111110, 5,  1, 2'd0, 4'd0, 0, 16'h4321, 4'b0000};
      rows[9]  = '{4'b0010, 7'b1011011, 5,  1, 2'd1, 4'd5, 0, 16'h4321, 4'b0000};
      rows[10] = '{4'b0100, 7'b0000000, 5,  1, 2'd2, 4'hF, 0, 16'h4321, 4'b0000};
      rows[11] = '{4'b1000, 7'b1110000, 5,  1, 2'd3, 4'd7, 1, 16'h7F50, 4'b0100};

      l_dig = '0;
      l_seg = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 mon_en = 1;
      repeat (3) begin
         @(negedge clk);
         l_dig = 4'($urandom);
         l_seg = 7'($urandom);
      end
      @(negedge clk);
      chk("rst_digit_valid", digit_valid, 0);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_bcd_out", bcd_out, 0);
      chk("rst_err_mask", err_mask, 0);
      chk("rst_digit_bcd", digit_bcd, 0);
      l_dig = '0;
      l_seg = '0;
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("idle_dv_count", dv_total, 0);
      chk("idle_bcd_out", bcd_out, 0);

      for (int i = 0; i < 12; i++) run_row(rows[i], $sformatf("row%0d", i));

      // partial frame discarded by a reset
      run_row('{4'b0001, 7'b0110000, 6, 1, 2'd0, 4'd1, 0, 16'h7F50, 4'b0100}, "mid_d0");
      run_row('{4'b0010, 7'b1101101, 6, 1, 2'd1, 4'd2, 0, 16'h7F50, 4'b0100}, "mid_d1");
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_bcd_out", bcd_out, 0);
      chk("midrst_err_mask", err_mask, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_row('{4'b0100, 7'b1111001, 6, 1, 2'd2, 4'd3, 0, 16'h0000, 4'b0000}, "mid_d2");
      run_row('{4'b1000, 7'b0110011, 6, 1, 2'd3, 4'd4, 0, 16'h0000, 4'b0000}, "mid_d3");
      run_row('{4'b0001, 7'b0110000, 6, 1, 2'd0, 4'd1, 0, 16'h0000, 4'b0000}, "mid_r0");
      run_row('{4'b0010, 7'b1101101, 6, 1, 2'd1, 4'd2, 1, 16'h4321, 4'b0000}, "mid_r1");

      // randomized scan traffic, checked cycle by cycle against the model
      for (int k = 0; k < 120; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0)      l_dig = '0;
         else if (r == 1) l_dig = 4'($urandom);
         else             l_dig = 4'(1 << $urandom_range(0, 3));
         if ($urandom_range(0, 4) != 0) l_seg = pat[$urandom_range(0, 9)];
         else                           l_seg = 7'($urandom);
         repeat ($urandom_range(1, 8)) @(negedge clk);
      end
      l_dig = '0;
      l_seg = '0;
      repeat (S + 2) @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
